// File: rtl/grover_pkg.sv
// Shared constants, state encoding and amplitude type for the Grover datapath stages.
// Amplitudes are signed Q1.6 (64 = 1.0).
package grover_pkg;

    localparam int NUM_BIT    = 3;
    localparam int AMP_W      = 8;
    localparam int NUM_SAMPLE = 2 ** NUM_BIT;
    localparam int SUM_W      = AMP_W + NUM_BIT;
    localparam int DIFF_W     = AMP_W + 2;

    localparam logic signed [AMP_W-1:0] AMP_ONE     = 8'sd64;
    localparam logic signed [AMP_W-1:0] AMP_UNIFORM = 8'sd23;  // 1/sqrt(8) in Q1.6

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DIFF,
        HOLD
    } state_t;

    typedef logic signed [AMP_W-1:0] amp_t;

endpackage

// File: rtl/amp_saturate.sv
// Clamp a DIFF_W-bit signed intermediate into the AMP_W-bit amplitude range.
// Purely combinational; sat flags that clamping took place.
module amp_saturate
    import grover_pkg::*;
(
    input  logic signed [DIFF_W-1:0] din,
    output logic signed [AMP_W-1:0]  dout,
    output logic                     sat
);

    localparam logic signed [DIFF_W-1:0] MAX_V = DIFF_W'(2 ** (AMP_W - 1) - 1);
    localparam logic signed [DIFF_W-1:0] MIN_V = DIFF_W'(-(2 ** (AMP_W - 1)));

    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    always_comb begin
        sat  = 1'b0;
        dout = amp_t'(din);
        if (din > MAX_V) begin
            sat  = 1'b1;
            dout = amp_t'(MAX_V);
        end else if (din < MIN_V) begin
            sat  = 1'b1;
            dout = amp_t'(MIN_V);
        end
    end

endmodule

// File: rtl/grover_diffuse.sv
// Grover diffusion stage: serially accumulates the mean of 8 amplitudes, then emits
// out_k = 2*mean - a_k with saturation, handed off through a valid/ready handshake.
module grover_diffuse
    import grover_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_SAMPLE*AMP_W-1:0]   in_amp,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_SAMPLE*AMP_W-1:0]   out_amp,
    output logic                          out_sat,
    output logic                          busy
);

    localparam logic [NUM_BIT-1:0] LAST_IDX = NUM_BIT'(NUM_SAMPLE - 1);

    state_t                   state;
    amp_t                     amp_mem [NUM_SAMPLE];
    logic signed [SUM_W-1:0]  sum;
    logic signed [SUM_W-1:0]  sum_next;
    logic [NUM_BIT-1:0]       idx;
    amp_t                     mean;
    amp_t                     mean_next;
    amp_t                     cur;
    amp_t                     sat_amp;
    logic signed [DIFF_W-1:0] diff_val;
    logic                     sat_flag;

    // The same lane read feeds both the accumulator and the subtractor.
    always_comb begin
        cur       = amp_mem[idx];
        sum_next  = sum + {{NUM_BIT{cur[AMP_W-1]}}, cur};
        mean_next = amp_t'(sum_next >>> NUM_BIT);
        diff_val  = {mean[AMP_W-1], mean, 1'b0} - {{2{cur[AMP_W-1]}}, cur};
    end

    amp_saturate u_sat (
        .din  (diff_val),
        .dout (sat_amp),
        .sat  (sat_flag)
    );

    // NOTE: the small amplitude file is reset along with everything else so an aborted
    // vector leaves nothing behind; larger memories would normally be left unreset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_amp   <= '0;
            out_sat   <= 1'b0;
            busy      <= 1'b0;
            sum       <= '0;
            idx       <= '0;
            mean      <= '0;
            for (int k = 0; k < NUM_SAMPLE; k++) begin
                amp_mem[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        for (int k = 0; k < NUM_SAMPLE; k++) begin
                            amp_mem[k] <= amp_t'(in_amp[k*AMP_W +: AMP_W]);
                        end
                        sum      <= '0;
                        idx      <= '0;
                        out_sat  <= 1'b0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ACCUM;
                    end
                end
                ACCUM: begin
                    sum <= sum_next;
                    idx <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        mean  <= mean_next;
                        state <= DIFF;
                    end
                end
                DIFF: begin
                    out_amp[idx*AMP_W +: AMP_W] <= sat_amp;
                    out_sat <= out_sat | sat_flag;
                    idx     <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
